// File: rtl/mips_pipe_ctrl.sv
// Pipeline control for the 5-stage MIPS core: ID decode, ID/EX..MEM/WB control registers,
// RAW/load-use stalls, branch/jump redirects, forwarding selects and a sticky illegal-opcode flag.
module mips_pipe_ctrl #(
    parameter int ALUC_W = 4,
    parameter int RA_W   = 5,
    parameter bit FWD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        id_opcode,
    input  logic [5:0]        id_func,
    input  logic [RA_W-1:0]   id_rs,
    input  logic [RA_W-1:0]   id_rt,
    input  logic [RA_W-1:0]   id_rd,
    input  logic              ex_zero,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic [1:0]        pc_src,
    output logic              ex_alu_src,
    output logic [ALUC_W-1:0] ex_alu_ctrl,
    output logic              ex_bne,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mem_write,
    output logic              mem_read,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic [RA_W-1:0]   wb_dest,
    output logic              illegal_op
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    typedef struct packed {
        logic       regWrite;
        logic       memToReg;
        logic       memWrite;
        logic       memRead;
        logic       aluSrc;
        logic       branch;
        logic       bne;
        logic [3:0] aluCode;
    } ctrlWord_t;

    ctrlWord_t       idWord;
    logic            idRegDst;
    logic            idJump;
    logic            idLegal;
    logic [RA_W-1:0] idDest;

    ctrlWord_t       exWord_q, exWord_d;
    logic [RA_W-1:0] exDest_q, exDest_d;
    logic [RA_W-1:0] exRs_q, exRs_d;
    logic [RA_W-1:0] exRt_q, exRt_d;

    logic            memRegWrite_q, memMemToReg_q, memMemWrite_q, memMemRead_q;
    logic [RA_W-1:0] memDest_q;
    logic            wbRegWrite_q, wbMemToReg_q;
    logic [RA_W-1:0] wbDest_q;
    logic            illegal_q, illegal_d;

    logic hazard, taken, stall, jumpGo, bubble;
    logic exHitRs, exHitRt, memHitRs, memHitRt;

    always_comb begin
        idWord   = '0;
        idRegDst = 1'b0;
        idJump   = 1'b0;
        idLegal  = 1'b1;
        case (id_opcode)
            OP_RTYPE: begin
                idWord.regWrite = 1'b1;
                idRegDst        = 1'b1;
                case (id_func)
                    6'h20, 6'h21: idWord.aluCode = 4'h0;
                    6'h22, 6'h23: idWord.aluCode = 4'h1;
                    6'h24:        idWord.aluCode = 4'h2;
                    6'h25:        idWord.aluCode = 4'h3;
                    6'h26:        idWord.aluCode = 4'h4;
                    6'h00:        idWord.aluCode = 4'h5;
                    6'h02:        idWord.aluCode = 4'h6;
                    6'h03:        idWord.aluCode = 4'h7;
                    6'h2a:        idWord.aluCode = 4'h8;
                    6'h2b:        idWord.aluCode = 4'h9;
                    6'h27:        idWord.aluCode = 4'hA;
                    6'h04:        idWord.aluCode = 4'hB;
                    6'h06:        idWord.aluCode = 4'hC;
                    6'h07:        idWord.aluCode = 4'hD;
                    default:      idWord.regWrite = 1'b0;
                endcase
            end
            OP_LW: begin
                idWord.regWrite = 1'b1;
                idWord.aluSrc   = 1'b1;
                idWord.memToReg = 1'b1;
                idWord.memRead  = 1'b1;
            end
            OP_SW: begin
                idWord.aluSrc   = 1'b1;
                idWord.memWrite = 1'b1;
            end
            OP_BEQ: begin
                idWord.branch  = 1'b1;
                idWord.aluCode = 4'h1;
            end
            OP_BNE: begin
                idWord.branch  = 1'b1;
                idWord.bne     = 1'b1;
                idWord.aluCode = 4'h1;
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU, OP_LUI: begin
                idWord.regWrite = 1'b1;
                idWord.aluSrc   = 1'b1;
                case (id_opcode)
                    OP_ANDI:  idWord.aluCode = 4'h2;
                    OP_ORI:   idWord.aluCode = 4'h3;
                    OP_XORI:  idWord.aluCode = 4'h4;
                    OP_SLTI:  idWord.aluCode = 4'h8;
                    OP_SLTIU: idWord.aluCode = 4'h9;
                    OP_LUI:   idWord.aluCode = 4'hE;
                    default:  idWord.aluCode = 4'h0;
                endcase
            end
            OP_J:    idJump  = 1'b1;
            default: idLegal = 1'b0;
        endcase
    end

    assign idDest = !idWord.regWrite ? '0 : (idRegDst ? id_rd : id_rt);

    // Register 0 never matches; dests are already zero for non-writing instructions.
    assign exHitRs  = (id_rs != '0) && (id_rs == exDest_q);
    assign exHitRt  = (id_rt != '0) && (id_rt == exDest_q);
    assign memHitRs = (id_rs != '0) && (id_rs == memDest_q);
    assign memHitRt = (id_rt != '0) && (id_rt == memDest_q);

    assign hazard = FWD_EN ? (exWord_q.memRead && (exHitRs || exHitRt))
                           : ((exWord_q.regWrite && (exHitRs || exHitRt)) ||
                              (memRegWrite_q && (memHitRs || memHitRt)));

    assign taken  = exWord_q.branch & (ex_zero ^ exWord_q.bne);
    assign stall  = hazard & ~taken & ~reset;
    assign jumpGo = idJump & ~stall & ~taken;
    assign bubble = stall | taken | ~idLegal;

    assign pc_write   = ~stall;
    assign ifid_write = ~stall;
    assign ifid_flush = ~reset & (taken | jumpGo);
    assign pc_src     = reset ? 2'b00 : (taken ? 2'b01 : (jumpGo ? 2'b10 : 2'b00));

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (FWD_EN && !reset) begin
            if (memRegWrite_q && (memDest_q != '0) && (memDest_q == exRs_q))
                fwd_a = 2'b10;
            else if (wbRegWrite_q && (wbDest_q != '0) && (wbDest_q == exRs_q))
                fwd_a = 2'b01;
            if (memRegWrite_q && (memDest_q != '0) && (memDest_q == exRt_q))
                fwd_b = 2'b10;
            else if (wbRegWrite_q && (wbDest_q != '0) && (wbDest_q == exRt_q))
                fwd_b = 2'b01;
        end
    end

    assign exWord_d  = bubble ? '0 : idWord;
    assign exDest_d  = bubble ? '0 : idDest;
    assign exRs_d    = bubble ? '0 : id_rs;
    assign exRt_d    = bubble ? '0 : id_rt;
    assign illegal_d = illegal_q | ~idLegal;

    // EX/MEM and MEM/WB never stall; only ID/EX takes bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            exWord_q      <= '0;
            exDest_q      <= '0;
            exRs_q        <= '0;
            exRt_q        <= '0;
            memRegWrite_q <= 1'b0;
            memMemToReg_q <= 1'b0;
            memMemWrite_q <= 1'b0;
            memMemRead_q  <= 1'b0;
            memDest_q     <= '0;
            wbRegWrite_q  <= 1'b0;
            wbMemToReg_q  <= 1'b0;
            wbDest_q      <= '0;
            illegal_q     <= 1'b0;
        end else begin
            exWord_q      <= exWord_d;
            exDest_q      <= exDest_d;
            exRs_q        <= exRs_d;
            exRt_q        <= exRt_d;
            memRegWrite_q <= exWord_q.regWrite;
            memMemToReg_q <= exWord_q.memToReg;
            memMemWrite_q <= exWord_q.memWrite;
            memMemRead_q  <= exWord_q.memRead;
            memDest_q     <= exDest_q;
            wbRegWrite_q  <= memRegWrite_q;
            wbMemToReg_q  <= memMemToReg_q;
            wbDest_q      <= memDest_q;
            illegal_q     <= illegal_d;
        end
    end

    assign ex_alu_src    = exWord_q.aluSrc;
    assign ex_alu_ctrl   = ALUC_W'(exWord_q.aluCode);
    assign ex_bne        = exWord_q.bne;
    assign mem_write     = memMemWrite_q;
    assign mem_read      = memMemRead_q;
    assign wb_reg_write  = wbRegWrite_q;
    assign wb_mem_to_reg = wbMemToReg_q;
    assign wb_dest       = wbDest_q;
    assign illegal_op    = illegal_q;

endmodule
